matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the `top_2dsys` systolic matmul array, replacing the hard-coded beat and cycle counts in the RIFFA channel controller with a runtime job descriptor. It accepts one job configuration and streams the X and W operands into the array. It then runs the compute phase, waits for the array to go idle, drains the results to an output stream, and clears the array for the next job. It sits between the RIFFA RX/TX channel logic (upstream and downstream streams) and one `top_2dsys` instance.

## Interface
- `AXI_WIDTH`, 128, width of the operand and result beats (matches `top_2dsys` `io_in`/`io_out`)
- `CNT_W`, 8, width of all beat and cycle counters and config fields
- `CLK`  in  1  single clock for the whole block
- `RST_N`  in  1  reset, synchronous and active-low
- `CFG_VALID`/`CFG_READY`  in/out  1  job descriptor handshake
- `CFG_X_BEATS`, `CFG_W_BEATS`, `CFG_START_CYC`, `CFG_OUT_BEATS`  in  CNT_W  X beats, W beats, `io_start` cycles, result beats
- `IN_DATA`  in  AXI_WIDTH  operand stream data (X beats first, then W beats)
- `IN_VALID`/`IN_READY`  in/out  1  operand stream handshake
- `OUT_DATA`  out  AXI_WIDTH  result stream data
- `OUT_VALID`/`OUT_READY`  out/in  1  result stream handshake
- `SA_IN`  out  AXI_WIDTH  drives `io_in`
- `SA_RW_CO`, `SA_WR_INPUT`, `SA_START`, `SA_IORMAC`, `SA_RD_OUTPUT`  out  1  drive the like-named `io_*` array controls
- `SA_WR_READY`, `SA_SYS_BUSY`, `SA_RD_READY`  in  1  array status
- `SA_OUT`  in  AXI_WIDTH  array `io_out`; first-word-fall-through, valid while `SA_RD_READY`=1
- `SA_CLEAR`  out  1  one-cycle pulse, ORed into the array reset by the parent
- `DONE`  out  1  one-cycle pulse at job end
- `ERR`  out  1  sticky flag for a rejected descriptor
- `STATE`  out  3  current state encoding, for debug

## Operation
- States: IDLE, LOAD_X, LOAD_W, COMPUTE, WAIT_BUSY, DRAIN, CLEAR.
- IDLE:
  - `CFG_READY`=1.
  - On `CFG_VALID`: latch all four fields.
  - Any field equal to 0: set `ERR`=1 and stay in IDLE.
  - Otherwise: clear `ERR`, clear the beat counter, go to LOAD_X.
- LOAD_X / LOAD_W:
  - `IN_READY` = `SA_WR_READY`; `SA_WR_INPUT` = `IN_VALID & IN_READY` (combinational); `SA_IN` = `IN_DATA`.
  - The counter increments on each transfer.
  - The transfer with count == beats-1 clears the counter and advances the state.
  - `SA_RW_CO`=1 in LOAD_X only. `SA_IORMAC`=1 in LOAD_X, LOAD_W and COMPUTE.
- COMPUTE: `SA_START`=1 for exactly `CFG_START_CYC` cycles, then go to WAIT_BUSY.
- WAIT_BUSY:
  - Ignore `SA_SYS_BUSY` in the first cycle (busy lags start).
  - From the second cycle, go to DRAIN when `SA_SYS_BUSY`=0.
- DRAIN:
  - `OUT_VALID` = `SA_RD_READY`; `OUT_DATA` = `SA_OUT`; `SA_RD_OUTPUT` = `OUT_VALID & OUT_READY`.
  - After `CFG_OUT_BEATS` transfers, go to CLEAR.
- CLEAR: `SA_CLEAR`=1 and `DONE`=1 for one cycle, then go to IDLE.
- `IN_READY`, `OUT_VALID`, `SA_START`, `SA_WR_INPUT` and `SA_RD_OUTPUT` are 0 in every state not listed for them.
- Counter arithmetic:
  - Unsigned, CNT_W bits; maximum job is 255 beats per phase.
  - Counters never wrap, because they compare against beats-1 before incrementing.

## Timing
- Reset: on a `CLK` edge with `RST_N`=0, state goes to IDLE, counters and `ERR` go to 0, and every output is 0 except `CFG_READY`=1. `SA_CLEAR` is not pulsed by reset.
- Reset mid-job abandons the job with no `DONE`. The parent resets the array with the same `RST_N`.
- Descriptor accepted at edge k: LOAD_X from k+1.
- With no stalls, each beat transfers in one cycle.
- Last W beat at edge j: COMPUTE from j+1. `SA_START` is high for cycles j+1 .. j+`CFG_START_CYC`.
- WAIT_BUSY lasts at least 2 cycles.
- CLEAR is exactly one cycle. `CFG_READY` returns on the following cycle.
- `IN_VALID` in any non-LOAD state is ignored (no transfer). Beats are never dropped or duplicated while `SA_WR_READY` toggles.
- `OUT_READY`=0 in DRAIN holds `SA_RD_OUTPUT`=0; `OUT_DATA` stays stable while `SA_RD_READY` holds.
- `CFG_VALID` outside IDLE is ignored.

## Structure
- `matmul_pkg`: state enum localparams (3-bit), `CNT_W` default, shared `AXI_WIDTH` default.
- One sub-module, `beat_counter`:
  - Inputs: load/clear, increment enable, limit.
  - Output: a `last` flag.
  - Used for the load, compute and drain phases.
- The top holds the FSM, config registers and combinational handshake steering.

## Test plan
- Descriptor X=6, W=6, START=16, OUT=4 with continuous streams:
  - 6 beats with `SA_RW_CO`=1, then 6 beats with `SA_RW_CO`=0.
  - `SA_START` high for 16 cycles.
  - Exactly 4 `OUT` beats, then one `SA_CLEAR`/`DONE` pulse.
- Same job with `SA_WR_READY` and `OUT_READY` randomly deasserted:
  - Beat order and count are unchanged.
  - No transfer occurs while ready=0.
- Descriptor with `CFG_OUT_BEATS`=0 -> `ERR`=1, state stays IDLE, no SA activity. A following valid descriptor -> `ERR`=0 and the job runs.
- `SA_SYS_BUSY` held 1 for 40 cycles after COMPUTE -> DRAIN entered on the cycle after busy falls. `SA_START` stays 0 throughout.
- `RST_N`=0 for one cycle during DRAIN -> next cycle IDLE, all outputs 0, `CFG_READY`=1, no `DONE`.
- Two back-to-back jobs with 1-beat phases (X=W=OUT=1, START=1) -> each job completes, CLEAR separates the jobs, `DONE` pulses twice.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared state encoding and width defaults for the systolic matmul job sequencer.
package matmul_pkg;
  localparam int AXI_WIDTH_DEF = 128;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_X    = 3'd1,
    ST_LOAD_W    = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_CLEAR     = 3'd6
  } state_t;
endpackage

// File: rtl/beat_counter.sv
// Up-counter with a terminal flag at limit-1; self-clears on the terminal increment.
module beat_counter
  import matmul_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Comparing against limit-1 before incrementing keeps a 255-beat phase from wrapping.
  assign last = (cnt == limit - CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for one top_2dsys array: load X/W, compute, wait idle, drain, clear.
//   state     | meaning
//   IDLE      | waiting for a job descriptor, CFG_READY high
//   LOAD_X    | streaming X beats into the array (SA_RW_CO high)
//   LOAD_W    | streaming W beats into the array
//   COMPUTE   | SA_START high for CFG_START_CYC cycles
//   WAIT_BUSY | first cycle ignores busy, then waits for SA_SYS_BUSY low
//   DRAIN     | forwarding CFG_OUT_BEATS results to the output stream
//   CLEAR     | one-cycle SA_CLEAR / DONE pulse
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int AXI_WIDTH = AXI_WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  input  logic [CNT_W-1:0]     CFG_X_BEATS,
  input  logic [CNT_W-1:0]     CFG_W_BEATS,
  input  logic [CNT_W-1:0]     CFG_START_CYC,
  input  logic [CNT_W-1:0]     CFG_OUT_BEATS,
  input  logic [AXI_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [AXI_WIDTH-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [AXI_WIDTH-1:0] SA_IN,
  output logic                 SA_RW_CO,
  output logic                 SA_WR_INPUT,
  output logic                 SA_START,
  output logic                 SA_IORMAC,
  output logic                 SA_RD_OUTPUT,
  input  logic                 SA_WR_READY,
  input  logic                 SA_SYS_BUSY,
  input  logic                 SA_RD_READY,
  input  logic [AXI_WIDTH-1:0] SA_OUT,
  output logic                 SA_CLEAR,
  output logic                 DONE,
  output logic                 ERR,
  output logic [2:0]           STATE
);

  state_t           state;
  logic [CNT_W-1:0] x_beats, w_beats, start_cyc, out_beats;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             busy_armed, err_q, done_q, clear_q;
  logic             in_load, in_drain, wr_xfer, rd_xfer, cfg_zero;

  assign in_load  = (state == ST_LOAD_X) || (state == ST_LOAD_W);
  assign in_drain = (state == ST_DRAIN);
  assign cfg_zero = (CFG_X_BEATS == '0) || (CFG_W_BEATS == '0) ||
                    (CFG_START_CYC == '0) || (CFG_OUT_BEATS == '0);

  assign CFG_READY    = (state == ST_IDLE);
  assign IN_READY     = in_load & SA_WR_READY;
  assign wr_xfer      = IN_VALID & IN_READY;
  assign SA_WR_INPUT  = wr_xfer;
  assign SA_IN        = in_load ? IN_DATA : '0;
  assign OUT_VALID    = in_drain & SA_RD_READY;
  assign OUT_DATA     = in_drain ? SA_OUT : '0;
  assign rd_xfer      = OUT_VALID & OUT_READY;
  assign SA_RD_OUTPUT = rd_xfer;
  assign SA_RW_CO     = (state == ST_LOAD_X);
  assign SA_IORMAC    = in_load || (state == ST_COMPUTE);
  assign SA_START     = (state == ST_COMPUTE);
  assign SA_CLEAR     = clear_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign STATE        = state;

  // One counter serves every phase; the limit follows the active phase.
  always_comb begin
    cnt_limit = '0;
    case (state)
      ST_LOAD_X:  cnt_limit = x_beats;
      ST_LOAD_W:  cnt_limit = w_beats;
      ST_COMPUTE: cnt_limit = start_cyc;
      ST_DRAIN:   cnt_limit = out_beats;
      default:    cnt_limit = '0;
    endcase
  end

  assign cnt_clr = (state == ST_IDLE);
  assign cnt_inc = wr_xfer | (state == ST_COMPUTE) | rd_xfer;

  beat_counter #(.CNT_W(CNT_W)) u_beat_counter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .last  (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      x_beats    <= '0;
      w_beats    <= '0;
      start_cyc  <= '0;
      out_beats  <= '0;
      busy_armed <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CFG_VALID) begin
            x_beats   <= CFG_X_BEATS;
            w_beats   <= CFG_W_BEATS;
            start_cyc <= CFG_START_CYC;
            out_beats <= CFG_OUT_BEATS;
            if (cfg_zero) begin
              err_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
              state <= ST_LOAD_X;
            end
          end
        end
        ST_LOAD_X: if (wr_xfer && cnt_last) state <= ST_LOAD_W;
        ST_LOAD_W: if (wr_xfer && cnt_last) state <= ST_COMPUTE;
        ST_COMPUTE: begin
          if (cnt_last) begin
            state      <= ST_WAIT_BUSY;
            busy_armed <= 1'b0;
          end
        end
        // Busy lags start by a cycle, so the first WAIT_BUSY cycle never exits.
        ST_WAIT_BUSY: begin
          if (!busy_armed)       busy_armed <= 1'b1;
          else if (!SA_SYS_BUSY) state      <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rd_xfer && cnt_last) begin
            state   <= ST_CLEAR;
            done_q  <= 1'b1;
            clear_q <= 1'b1;
          end
        end
        ST_CLEAR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: operand/result queues plus phase timing checks.
module tb_matmul_seq_ctrl;
  localparam int AW = 128;
  localparam int CW = 8;

  logic          CLK;
  logic          RST_N;
  logic          CFG_VALID, CFG_READY;
  logic [CW-1:0] CFG_X_BEATS, CFG_W_BEATS, CFG_START_CYC, CFG_OUT_BEATS;
  logic [AW-1:0] IN_DATA, OUT_DATA, SA_IN, SA_OUT;
  logic          IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic          SA_RW_CO, SA_WR_INPUT, SA_START, SA_IORMAC, SA_RD_OUTPUT;
  logic          SA_WR_READY, SA_SYS_BUSY, SA_RD_READY;
  logic          SA_CLEAR, DONE, ERR;
  logic [2:0]    STATE;

  typedef struct {
    logic [AW-1:0] data;
    logic          rwco;
  } in_exp_t;

  in_exp_t       exp_in[$];
  logic [AW-1:0] exp_out[$];
  int            errors = 0;
  int            checks = 0;

  matmul_seq_ctrl #(.AXI_WIDTH(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_X_BEATS(CFG_X_BEATS), .CFG_W_BEATS(CFG_W_BEATS),
    .CFG_START_CYC(CFG_START_CYC), .CFG_OUT_BEATS(CFG_OUT_BEATS),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SA_IN(SA_IN), .SA_RW_CO(SA_RW_CO), .SA_WR_INPUT(SA_WR_INPUT),
    .SA_START(SA_START), .SA_IORMAC(SA_IORMAC), .SA_RD_OUTPUT(SA_RD_OUTPUT),
    .SA_WR_READY(SA_WR_READY), .SA_SYS_BUSY(SA_SYS_BUSY), .SA_RD_READY(SA_RD_READY),
    .SA_OUT(SA_OUT), .SA_CLEAR(SA_CLEAR), .DONE(DONE), .ERR(ERR), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cfg_ready"}, AW'(CFG_READY), AW'(1));
    chk({tag, "_in_ready"},  AW'(IN_READY), AW'(0));
    chk({tag, "_wr_input"},  AW'(SA_WR_INPUT), AW'(0));
    chk({tag, "_sa_in"},     SA_IN, AW'(0));
    chk({tag, "_out_valid"}, AW'(OUT_VALID), AW'(0));
    chk({tag, "_out_data"},  OUT_DATA, AW'(0));
    chk({tag, "_rd_output"}, AW'(SA_RD_OUTPUT), AW'(0));
    chk({tag, "_rw_co"},     AW'(SA_RW_CO), AW'(0));
    chk({tag, "_iormac"},    AW'(SA_IORMAC), AW'(0));
    chk({tag, "_start"},     AW'(SA_START), AW'(0));
    chk({tag, "_clear"},     AW'(SA_CLEAR), AW'(0));
    chk({tag, "_done"},      AW'(DONE), AW'(0));
    chk({tag, "_err"},       AW'(ERR), AW'(0));
    chk({tag, "_state"},     AW'(STATE), AW'(0));
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic run_job(input int x, input int w, input int st, input int ob,
                         input bit stall, input int busy_len, input bit abort_drain);
    int nin = x + w;
    int idx = 0, ridx = 0, pres_in = -1, pres_out = -1, cyc = 0;
    int n_wr = 0, n_rwco = 0, n_start = 0, n_rd = 0, n_done = 0, n_clear = 0;
    int first_wr = -1, last_wr = -1, first_start = -1, last_start = -1;
    int first_out = -1, last_rd = -1, done_c = -1, fall_c = -1, busy_left = 0;
    bit wr_adv, rd_adv, prev_busy = 0, finished = 0;
    logic [AW-1:0] cur_in = '0, cur_out = '0, eo;
    in_exp_t e;

    CFG_VALID = 1'b1;
    CFG_X_BEATS = CW'(x); CFG_W_BEATS = CW'(w);
    CFG_START_CYC = CW'(st); CFG_OUT_BEATS = CW'(ob);
    @(negedge CLK);
    chk("cfg_ready", AW'(CFG_READY), AW'(1));
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
    CFG_X_BEATS = '0; CFG_W_BEATS = '0; CFG_START_CYC = '0; CFG_OUT_BEATS = '0;

    while (!finished && cyc < 3000) begin
      if (idx < nin && pres_in != idx) begin
        cur_in = {$urandom, $urandom, $urandom, $urandom};
        exp_in.push_back('{data: cur_in, rwco: (idx < x)});
        pres_in = idx;
      end
      IN_VALID    = 1'b1;
      IN_DATA     = (idx < nin) ? cur_in : AW'(128'hBAD0_BAD0);
      SA_WR_READY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      OUT_READY   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ridx < ob && pres_out != ridx) begin
        cur_out = {$urandom, $urandom, $urandom, $urandom};
        exp_out.push_back(cur_out);
        pres_out = ridx;
      end
      SA_RD_READY = (ridx < ob);
      SA_OUT      = (ridx < ob) ? cur_out : '0;
      SA_SYS_BUSY = (busy_left > 0);
      if (prev_busy && !SA_SYS_BUSY) fall_c = cyc;
      prev_busy = SA_SYS_BUSY;

      @(negedge CLK);
      if (cyc == 0) chk("err_cleared", AW'(ERR), AW'(0));
      if (SA_WR_INPUT) begin
        chk("wr_ready", AW'(SA_WR_READY), AW'(1));
        chk("wr_iormac", AW'(SA_IORMAC), AW'(1));
        n_wr++;
        if (SA_RW_CO) n_rwco++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_in.size() == 0) chk("wr_extra", AW'(SA_WR_INPUT), AW'(0));
        else begin
          e = exp_in.pop_front();
          chk("sa_in", SA_IN, e.data);
          chk("rw_co", AW'(SA_RW_CO), AW'(e.rwco));
        end
      end
      if (SA_START) begin
        n_start++;
        chk("start_iormac", AW'(SA_IORMAC), AW'(1));
        if (first_start < 0) first_start = cyc;
        last_start = cyc;
        if (n_start == st) busy_left = busy_len;
      end
      if (SA_SYS_BUSY) chk("start_busy", AW'(SA_START), AW'(0));
      if (OUT_VALID) begin
        if (first_out < 0) first_out = cyc;
        if (!OUT_READY) chk("rd_hold", AW'(SA_RD_OUTPUT), AW'(0));
        if (OUT_READY) begin
          n_rd++;
          last_rd = cyc;
          if (exp_out.size() == 0) chk("out_extra", AW'(OUT_VALID), AW'(0));
          else begin
            eo = exp_out.pop_front();
            chk("out_data", OUT_DATA, eo);
          end
        end
      end
      if (SA_CLEAR) n_clear++;
      if (DONE) begin
        n_done++;
        done_c = cyc;
        chk("done_clear", AW'(SA_CLEAR), AW'(1));
        finished = 1;
      end
      wr_adv = IN_READY;
      rd_adv = SA_RD_OUTPUT;

      @(posedge CLK); #1;
      cyc++;
      if (wr_adv && idx < nin) idx++;
      if (rd_adv && ridx < ob) ridx++;
      if (SA_SYS_BUSY) busy_left--;
      if (abort_drain && first_out >= 0) finished = 1;
    end

    if (abort_drain) begin
      chk("abort_reached", AW'(first_out >= 0), AW'(1));
      exp_in.delete();
      exp_out.delete();
    end else begin
      chk("timeout", AW'(n_done), AW'(1));
      chk("n_wr", AW'(n_wr), AW'(nin));
      chk("n_rw_co", AW'(n_rwco), AW'(x));
      chk("n_start", AW'(n_start), AW'(st));
      chk("n_out", AW'(n_rd), AW'(ob));
      chk("n_clear", AW'(n_clear), AW'(1));
      chk("in_left", AW'(exp_in.size()), AW'(0));
      chk("out_left", AW'(exp_out.size()), AW'(0));
      if (!stall) begin
        chk("first_wr_cyc", AW'(first_wr), AW'(0));
        chk("start_after_w", AW'(first_start), AW'(last_wr + 1));
        if (busy_len > 0) chk("drain_after_busy", AW'(first_out), AW'(fall_c + 1));
        else              chk("drain_after_wait", AW'(first_out), AW'(last_start + 3));
        chk("done_after_drain", AW'(done_c), AW'(last_rd + 1));
      end
      @(negedge CLK);
      chk("cfg_ready_back", AW'(CFG_READY), AW'(1));
      chk("done_single", AW'(DONE), AW'(0));
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RST_N = 1'b0;
    CFG_VALID = 1'b0;
    CFG_X_BEATS = '0; CFG_W_BEATS = '0; CFG_START_CYC = '0; CFG_OUT_BEATS = '0;
    IN_VALID = 1'b1; IN_DATA = AW'(128'h1234_5678);
    OUT_READY = 1'b1;
    SA_WR_READY = 1'b1; SA_SYS_BUSY = 1'b0; SA_RD_READY = 1'b1;
    SA_OUT = AW'(128'h9ABC_DEF0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_idle_outputs("por");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk_idle_outputs("post_rst");
    @(posedge CLK); #1;

    run_job(6, 6, 16, 4, 1'b0, 0, 1'b0);
    run_job(6, 6, 16, 4, 1'b1, 0, 1'b0);

    // Rejected descriptor: zero result beats.
    CFG_VALID = 1'b1;
    CFG_X_BEATS = 8'd6; CFG_W_BEATS = 8'd6; CFG_START_CYC = 8'd16; CFG_OUT_BEATS = 8'd0;
    IN_VALID = 1'b1; SA_WR_READY = 1'b1;
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("bad_err", AW'(ERR), AW'(1));
      chk("bad_state", AW'(STATE), AW'(0));
      chk("bad_cfg_ready", AW'(CFG_READY), AW'(1));
      chk("bad_wr_input", AW'(SA_WR_INPUT), AW'(0));
      chk("bad_start", AW'(SA_START), AW'(0));
      chk("bad_iormac", AW'(SA_IORMAC), AW'(0));
    end
    @(posedge CLK); #1;
    run_job(2, 3, 4, 2, 1'b0, 0, 1'b0);

    run_job(6, 6, 16, 4, 1'b0, 40, 1'b0);

    // Reset in the middle of DRAIN.
    run_job(6, 6, 16, 4, 1'b0, 0, 1'b1);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk_idle_outputs("mid_rst");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("mid_rst_no_done", AW'(DONE), AW'(0));
    end
    @(posedge CLK); #1;

    run_job(1, 1, 1, 1, 1'b0, 0, 1'b0);
    run_job(1, 1, 1, 1, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
